shift_cmd_sequencer: RTL and testbench
======================================

// Module: shift_cmd_sequencer
// PURPOSE
//  Upstream command generator for the bidirectional 4-bit shift register stage.
//  Stores a short program of 8-bit command words, then plays them back into the
//  register's i_DATA. Command word: [7:6]=S1S0 mode, [5]=Il, [4]=Id, [3:0]=I3..I0.
//  Each word is held for a programmed number of cycles. Idle output is HOLD (8'h00).
// PARAMETERS
//  DEPTH  16  program memory entries (power of 2, >=2)
//  REP_W  4   width of per-entry repeat field; entry is held REP+1 cycles
// PORTS
//  i_clk    in   1              clock, rising edge
//  i_rst_n  in   1              asynchronous, active-low reset
//  i_wr_en  in   1              append {i_REP,i_DATA} at o_count
//  i_DATA   in   8              command word to store
//  i_REP    in   REP_W          hold count minus one for this entry
//  i_clr    in   1              clear program (count:=0), aborts playback
//  i_start  in   1              begin playback from entry 0
//  i_stop   in   1              abort playback
//  o_DATA   out  8              command word to shift register stage
//  o_busy   out  1              playback in progress
//  o_done   out  1              one-cycle pulse after last entry completes
//  o_full   out  1              o_count == DEPTH
//  o_count  out  $clog2(DEPTH+1) number of stored entries
//  o_idx    out  $clog2(DEPTH)  entry currently driven (0 when idle)
// BEHAVIOUR
//  - Reset (async, any time): state IDLE, count/idx/rep counter 0; o_DATA=8'h00,
//    o_busy=0, o_done=0, o_full=0, o_count=0, o_idx=0. Memory contents don't-care.
//  - FSM: IDLE -> PLAY on i_start with count>0; IDLE -> DONE on i_start with count==0;
//    PLAY -> PLAY (next entry / same entry); PLAY -> DONE after last entry's final cycle;
//    PLAY -> IDLE on i_stop or i_clr; DONE -> IDLE unconditionally (1 cycle).
//  - Latency: i_start sampled at edge N -> o_DATA = mem[0] from edge N+1.
//  - Entry k driven exactly mem[k].REP+1 cycles, then k+1 follows with no gap.
//  - o_DATA is registered; 8'h00 in IDLE and DONE. o_busy=1 only in PLAY.
//  - o_done high exactly during DONE; not asserted on i_stop/i_clr abort.
//  - Writes accepted only in IDLE and only when count<DEPTH; else ignored,
//    count unchanged (writes while full or busy are silently dropped).
//  - Priority in one cycle: i_clr > i_stop > i_start > i_wr_en. In IDLE, a write
//    coinciding with i_start is dropped; i_stop in IDLE/DONE has no effect.
//  - i_clr: count:=0 next edge; if in PLAY, o_DATA:=8'h00, o_busy:=0 next edge.
//  - Program is retained after playback/stop; i_start replays it.
//  - Repeat counter is REP_W bits, counts down from REP to 0; REP=all-ones legal.
// CONFIGURATION
//  SHIFT_SEQ_LOOP_EN defined: adds input i_loop (1 bit). In PLAY, if i_loop=1 at
//   the last entry's final cycle, idx wraps to 0 with no gap and no o_done; loop
//   ends only via i_stop/i_clr, or by dropping i_loop before the wrap point.
//  Not defined: no i_loop port; playback always ends in DONE after the last entry.
// STRUCTURE
//  Package shift_seq_pkg: eSeq_state_t {IDLE, PLAY, DONE}; mode constants
//   MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHL=2'b10, MODE_SHR=2'b11;
//   HOLD_WORD=8'h00.
//  Sub-module seq_prog_mem: DEPTH x (8+REP_W) register array, sync write,
//   async read; pointers and FSM remain in shift_cmd_sequencer.
// TESTING
//  1 Write {REP=0,8'h45},{REP=2,8'h80},{REP=0,8'hC0}; start -> o_DATA 45,80,80,80,
//    C0, then 00 with o_done=1 for 1 cycle; o_busy high exactly 5 cycles.
//  2 Write 16 entries then a 17th -> o_full=1, o_count=16, 17th never played.
//  3 Start with empty program -> o_done pulse next cycle, o_busy stays 0.
//  4 Two entries REP=3 each; i_stop in cycle 2 -> o_DATA=00 next edge, no o_done;
//    i_start again -> replays from entry 0.
//  5 Deassert i_rst_n mid-PLAY between edges -> outputs 00/0 immediately,
//    o_count=0 after release.
//  6 (SHIFT_SEQ_LOOP_EN) i_loop=1, entries 41,82 REP=0 -> 41,82,41,82,... no
//    o_done; i_loop=0 -> ends after next 82 with o_done.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift-register command sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } eSeq_state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_SHR  = 2'b11;

  localparam logic [7:0] HOLD_WORD = 8'h00;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: DEPTH x W register array,
// synchronous write, asynchronous read. Contents are not reset.
module seq_prog_mem
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 12,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: one entry per accepted append.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem_q[i_rd_addr];

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Plays a stored program of {REP, command} words into the shift register stage.
// Optional feature macro: SHIFT_SEQ_LOOP_EN (adds i_loop for continuous replay).
module shift_cmd_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int REP_W = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [7:0]       i_DATA,
  input  logic [REP_W-1:0] i_REP,
  input  logic             i_clr,
  input  logic             i_start,
  input  logic             i_stop,
`ifdef SHIFT_SEQ_LOOP_EN
  input  logic             i_loop,
`endif
  output logic [7:0]       o_DATA,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_full,
  output logic [CW-1:0]    o_count,
  output logic [IW-1:0]    o_idx
);

  localparam int EW = 8 + REP_W;

  eSeq_state_t      state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             full_q, full_d;

  logic             wr_en_s;
  logic             last_s;
  logic             loop_s;
  logic [IW-1:0]    rd_addr_s;
  logic [EW-1:0]    rd_entry_s;

`ifdef SHIFT_SEQ_LOOP_EN
  assign loop_s = i_loop;
`else
  assign loop_s = 1'b0;
`endif

  assign last_s = ((CW'(idx_q) + CW'(1)) == count_q);
  // The single read port always looks at the entry that would be loaded next.
  assign rd_addr_s = ((state_q == PLAY) && !last_s) ? (idx_q + IW'(1)) : IW'(0);

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .i_clk     (i_clk),
    .i_wr_en   (wr_en_s),
    .i_wr_addr (count_q[IW-1:0]),
    .i_wr_data ({i_REP, i_DATA}),
    .i_rd_addr (rd_addr_s),
    .o_rd_data (rd_entry_s)
  );

  // Next-state and next-output logic; priority is clr > stop > start > write.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wr_en_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_clr) begin
          count_d = CW'(0);
        end else if (i_stop) begin
          count_d = count_q;
        end else if (i_start) begin
          if (count_q != CW'(0)) begin
            state_d = PLAY;
            idx_d   = IW'(0);
            rep_d   = rd_entry_s[EW-1:8];
            data_d  = rd_entry_s[7:0];
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (i_wr_en && (count_q != CW'(DEPTH))) begin
          wr_en_s = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      PLAY: begin
        if (i_clr || i_stop) begin
          state_d = IDLE;
          idx_d   = IW'(0);
          rep_d   = REP_W'(0);
          data_d  = HOLD_WORD;
          busy_d  = 1'b0;
          if (i_clr) begin
            count_d = CW'(0);
          end else begin
            count_d = count_q;
          end
        end else if (rep_q != REP_W'(0)) begin
          rep_d = rep_q - REP_W'(1);
        end else if (!last_s || loop_s) begin
          idx_d  = rd_addr_s;
          rep_d  = rd_entry_s[EW-1:8];
          data_d = rd_entry_s[7:0];
        end else begin
          state_d = DONE;
          idx_d   = IW'(0);
          data_d  = HOLD_WORD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (i_clr) begin
          count_d = CW'(0);
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = IW'(0);
        rep_d   = REP_W'(0);
        data_d  = HOLD_WORD;
        busy_d  = 1'b0;
      end
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= CW'(0);
      idx_q   <= IW'(0);
      rep_q   <= REP_W'(0);
      data_q  <= HOLD_WORD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  assign o_DATA  = data_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_full  = full_q;
  assign o_count = count_q;
  assign o_idx   = idx_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Scoreboard bench for shift_cmd_sequencer; loop tests need SHIFT_SEQ_LOOP_EN.
module tb_shift_cmd_sequencer;
  import shift_seq_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] idx;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct packed {
    logic [3:0] rep;
    logic [7:0] d;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_wr_en = 1'b0;
  logic [7:0] i_DATA = 8'h00;
  logic [3:0] i_REP = 4'h0;
  logic       i_clr = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_loop = 1'b0;
  logic [7:0] o_DATA;
  logic       o_busy, o_done, o_full;
  logic [4:0] o_count;
  logic [3:0] o_idx;

  exp_t exp_q[$];
  ent_t prog[$];
  int   total = 0;
  int   bad = 0;

  shift_cmd_sequencer #(.DEPTH(16), .REP_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_wr_en (i_wr_en),
    .i_DATA  (i_DATA),
    .i_REP   (i_REP),
    .i_clr   (i_clr),
    .i_start (i_start),
    .i_stop  (i_stop),
`ifdef SHIFT_SEQ_LOOP_EN
    .i_loop  (i_loop),
`endif
    .o_DATA  (o_DATA),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_full  (o_full),
    .o_count (o_count),
    .o_idx   (o_idx)
  );

  always #5 clk = ~clk;

  // Monitor: every busy/done cycle must match the head of the expected stream.
  always @(negedge clk) begin
    if (rst_n && (o_busy || o_done)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got d=%h idx=%0d busy=%b done=%b want nothing", o_DATA, o_idx, o_busy, o_done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_DATA !== e.d || o_idx !== e.idx || o_busy !== e.busy || o_done !== e.done) begin
          bad++;
          $display("FAIL stream: got d=%h idx=%0d busy=%b done=%b want d=%h idx=%0d busy=%b done=%b",
                   o_DATA, o_idx, o_busy, o_done, e.d, e.idx, e.busy, e.done);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_data"}, 32'(o_DATA), 32'h0);
    chk({name, "_flags"}, {29'd0, o_busy, o_done, o_full}, {29'd0, 1'b0, 1'b0, prog.size() == 16});
    chk({name, "_count"}, 32'(o_count), 32'(prog.size()));
    chk({name, "_idx"}, 32'(o_idx), 32'h0);
  endtask

  task automatic wr(input logic [7:0] d, input logic [3:0] r);
    i_wr_en = 1'b1; i_DATA = d; i_REP = r;
    tick();
    i_wr_en = 1'b0;
    if (prog.size() < 16) prog.push_back({r, d});
  endtask

  task automatic clr();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    prog.delete();
  endtask

  // One pass over the program: entry k appears rep+1 times.
  task automatic push_pass(input int limit);
    for (int k = 0; k < prog.size(); k++)
      for (int r = 0; r <= int'(prog[k].rep); r++)
        if (exp_q.size() < limit) exp_q.push_back({prog[k].d, 4'(k), 1'b1, 1'b0});
  endtask

  task automatic push_done();
    exp_q.push_back({8'h00, 4'h0, 1'b0, 1'b1});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    i_wr_en = 1'b0;
    chk({name, "_drain"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic run_full(input string name);
    push_pass(100000);
    push_done();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_wr_en = 1'b1;
    i_DATA = 8'($urandom);
    drain(name);
    tick();
    check_idle(name);
  endtask

  task automatic run_abort(input string name, input int s, input bit use_clr);
    push_pass(s);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (s - 1) tick();
    if (use_clr) i_clr = 1'b1; else i_stop = 1'b1;
    tick();
    i_clr = 1'b0; i_stop = 1'b0;
    if (use_clr) prog.delete();
    chk({name, "_left"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    check_idle(name);
  endtask

  function automatic int stream_len();
    int l = 0;
    for (int k = 0; k < prog.size(); k++) l += int'(prog[k].rep) + 1;
    return l;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed: 45, 80 x3, C0 then done.
    wr(8'h45, 4'd0); wr(8'h80, 4'd2); wr(8'hC0, 4'd0);
    check_idle("t1_prog");
    run_full("t1");
    run_full("t1_replay");

    // Empty program start gives a lone done pulse.
    clr();
    check_idle("t3_clr");
    run_full("t3");

    // Fill past capacity; the 17th write is dropped.
    for (int i = 0; i < 17; i++) wr({MODE_LOAD, 6'(i)}, 4'($urandom_range(0, 2)));
    check_idle("t2_full");
    run_full("t2");

    // Stop in cycle 2, then replay from entry 0.
    clr();
    wr(8'hA5, 4'd3); wr(8'h5A, 4'd3);
    run_abort("t4_stop", 2, 1'b0);
    run_full("t4_replay");

    // Randomised programs with full or aborted playback.
    for (int it = 0; it < 10; it++) begin
      int n;
      clr();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic [1:0] m;
        case ($urandom_range(0, 3))
          0: m = MODE_HOLD;
          1: m = MODE_LOAD;
          2: m = MODE_SHL;
          default: m = MODE_SHR;
        endcase
        wr({m, 6'($urandom)}, 4'($urandom));
      end
      if ($urandom_range(0, 1) == 0) run_full("rnd_full");
      else run_abort("rnd_abort", $urandom_range(1, stream_len()), 1'($urandom));
    end

    // Asynchronous reset mid-playback.
    clr();
    wr(8'h11, 4'd15); wr(8'h22, 4'd15);
    push_pass(100000);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async", {o_DATA, o_busy, o_done, o_full, 3'b000, o_count, o_idx},
        {8'h00, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 4'd0});
    exp_q.delete();
    prog.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("t5_after");

`ifdef SHIFT_SEQ_LOOP_EN
    wr(8'h41, 4'd0); wr(8'h82, 4'd0);
    push_pass(100000); push_pass(100000); push_pass(100000);
    push_done();
    i_loop = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (4) tick();
    i_loop = 1'b0;
    drain("t6_loop");
    tick();
    check_idle("t6_loop");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
